rank_match_sched: RTL and testbench
===================================

Name: rank_match_sched

Overview:
Controller that sequences one shared XOR template scorer over all rank kernels after each rank-corner mask capture. The scorer computes a per-template mismatch count. This block selects the kernel index, issues start pulses and collects scores. It tracks the best (lowest) and second-best scores and publishes the winning rank with a confidence flag. It sits between the corner-capture logic and the card-identification output stage.

Parameters:
NUM_TEMPLATES, 13, number of rank kernels (A..K), index 0..NUM_TEMPLATES-1
SCORE_W, 11, scorer score width ($clog2(28*40))
MARGIN_MIN, 40, minimum (second_score - best_score) for confident
TIMEOUT_CYCLES, 2048, max cycles to wait for scorer_done per template

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
capture_done  in  1  one-cycle pulse: mask window fully written
sel_template  out  $clog2(NUM_TEMPLATES)  kernel index driven to scorer
scorer_start  out  1  one-cycle pulse: begin scoring sel_template
scorer_done  in  1  one-cycle pulse: scorer_score valid this cycle
scorer_score  in  SCORE_W  mismatch count for sel_template
busy  out  1  high from accepted capture_done until result/abort
result_valid  out  1  one-cycle pulse: result outputs updated
best_rank  out  $clog2(NUM_TEMPLATES)  index of lowest score
best_score  out  SCORE_W  lowest score
second_score  out  SCORE_W  second-lowest score
confident  out  1  (second_score - best_score) >= MARGIN_MIN
overrun  out  1  sticky: capture_done arrived while busy
timeout_err  out  1  sticky: scorer_done not seen within TIMEOUT_CYCLES

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; best/second trackers 0; internal counters 0.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: on capture_done -> ISSUE. Set idx=0, best=all-ones, second=all-ones, best_rank=0, busy=1. Results outputs hold their previous values.
- ISSUE: scorer_start=1 for exactly one cycle with sel_template=idx. Watchdog clears -> WAIT.
- Latency: capture_done at cycle N -> scorer_start at N+1.
- WAIT: sel_template held stable. On scorer_done:
  - If score < best: second<=best, best<=score, best_rank<=idx.
  - Else if score < second: second<=score.
  - Ties keep the lower index: strict less-than.
  - If idx==NUM_TEMPLATES-1 -> FINISH; else idx+1 -> ISSUE.
- scorer_done outside WAIT is ignored.
- Watchdog: counts cycles in WAIT. When it reaches TIMEOUT_CYCLES without scorer_done: set timeout_err, busy<=0, return to IDLE. No result_valid is issued and result outputs are unchanged.
- FINISH (one cycle): register best_rank/best_score/second_score and compute confident using unsigned subtraction; second >= best always holds. Next cycle result_valid=1 for one cycle and busy=0; return to IDLE.
- Latency: last scorer_done at cycle M -> result_valid at M+2.
- capture_done while busy: ignored (sequence continues unaffected); overrun<=1.
- capture_done in the same cycle as result_valid: treated as busy, so it is dropped and sets overrun.
- overrun and timeout_err clear only on reset.
- Reset mid-sequence: immediate return to IDLE, no pulses emitted, outputs 0.
- A scorer that never reports a score below all-ones leaves best_score=all-ones, second=all-ones, confident=0 (margin 0 < MARGIN_MIN).

Decomposition:
- Shared package rank_match_pkg: state enum (IDLE, ISSUE, WAIT, FINISH); constant NUM_RANKS=13; rank index typedef rank_idx_t; score typedef score_t.
- One natural sub-module: top2_min_tracker. It holds best/second/best_rank, with clear and update(score, idx) inputs and strict-less-than tie rule. The FSM and watchdog stay in rank_match_sched.

Test Plan:
- Nominal sweep: pulse capture_done; bench model returns scores 500 for all indices except idx 8 = 120 (done 30 cycles after each start) -> 13 scorer_start pulses with sel_template 0..12; result_valid with best_rank=8, best_score=120, second_score=500, confident=1.
- Low margin: idx 3 = 200, idx 11 = 220, others 600 -> best_rank=3, second_score=220, confident=0 (margin 20 < 40).
- Tie: idx 2 and idx 7 both 150, others 900 -> best_rank=2, best_score=150, second_score=150, confident=0.
- Overrun: second capture_done 5 cycles after the first -> overrun=1; exactly 13 starts and one result_valid; no restart.
- Timeout: bench withholds scorer_done for idx 4 -> timeout_err=1 at 2048 cycles in WAIT; busy=0; no result_valid; prior results unchanged. A subsequent capture_done runs a full sweep normally.
- Async reset: assert rst=0 mid-WAIT at idx 6, asynchronous to clk -> all outputs 0 immediately; after release, no scorer_start until a new capture_done.

Source files
------------

// File: rtl/rank_match_pkg.sv
// Shared types and constants for the rank template scheduler.
// The sweep states are plain localparam codes rather than an enum so that older tools can read them.
package rank_match_pkg;

  localparam int NUM_RANKS = 13;
  localparam int SCORE_W   = 11;
  localparam int RANK_W    = $clog2(NUM_RANKS);

  typedef logic [RANK_W-1:0]  rank_idx_t;
  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [1:0]         state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ISSUE  = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t FINISH = 2'd3;

endpackage

// File: rtl/rank_match_sched_if.sv
// Handshake between the scheduler (master) and the shared XOR template scorer (slave).
interface rank_match_sched_if;
  import rank_match_pkg::*;

  rank_idx_t sel_template;
  logic      scorer_start;
  logic      scorer_done;
  score_t    scorer_score;

  modport master (output sel_template, output scorer_start,
                  input  scorer_done,  input  scorer_score);
  modport slave  (input  sel_template, input  scorer_start,
                  output scorer_done,  output scorer_score);

endinterface

// File: rtl/rank_match_sched_top2.sv
// Tracks the lowest and second-lowest scores seen in one sweep.
// A tie goes to the earlier index because the comparison is strictly less-than.
module top2_min_tracker
  import rank_match_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      update,
  input  score_t    score,
  input  rank_idx_t idx,
  output score_t    best,
  output score_t    second,
  output rank_idx_t best_rank
);

  score_t    best_q, best_d;
  score_t    second_q, second_d;
  rank_idx_t rank_q, rank_d;

  always_comb begin
    best_d   = best_q;
    second_d = second_q;
    rank_d   = rank_q;
    if (clear) begin
      best_d   = '1;
      second_d = '1;
      rank_d   = '0;
    end else if (update) begin
      if (score < best_q) begin
        second_d = best_q;
        best_d   = score;
        rank_d   = idx;
      end else if (score < second_q) begin
        second_d = score;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q   <= '0;
      second_q <= '0;
      rank_q   <= '0;
    end else begin
      best_q   <= best_d;
      second_q <= second_d;
      rank_q   <= rank_d;
    end
  end

  assign best      = best_q;
  assign second    = second_q;
  assign best_rank = rank_q;

endmodule

// File: rtl/rank_match_sched.sv
// Runs the shared scorer over every rank kernel after each corner capture.
// It publishes the lowest-scoring rank together with a confidence flag based on the score margin.
module rank_match_sched
  import rank_match_pkg::*;
#(
  parameter int NUM_TEMPLATES  = NUM_RANKS,
  parameter int MARGIN_MIN     = 40,
  parameter int TIMEOUT_CYCLES = 2048
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_done,
  rank_match_sched_if.master sc,
  output logic               busy,
  output logic               result_valid,
  output rank_idx_t          best_rank,
  output score_t             best_score,
  output score_t             second_score,
  output logic               confident,
  output logic               overrun,
  output logic               timeout_err
);

  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam rank_idx_t         LAST_IDX = rank_idx_t'(NUM_TEMPLATES - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  rank_idx_t       idx_q, idx_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            rv_q, rv_d;
  rank_idx_t       rank_q, rank_d;
  score_t          best_q, best_d;
  score_t          second_q, second_d;
  logic            conf_q, conf_d;
  logic            overrun_q, overrun_d;
  logic            timeout_q, timeout_d;

  logic            trk_clear, trk_update;
  score_t          trk_best, trk_second, margin;
  rank_idx_t       trk_rank;

  top2_min_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (trk_clear),
    .update    (trk_update),
    .score     (sc.scorer_score),
    .idx       (idx_q),
    .best      (trk_best),
    .second    (trk_second),
    .best_rank (trk_rank)
  );

  assign margin = trk_second - trk_best;

  // The cycle that pulses result_valid still counts as busy, so a capture arriving then is dropped.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wd_d       = wd_q;
    rv_d       = 1'b0;
    rank_d     = rank_q;
    best_d     = best_q;
    second_d   = second_q;
    conf_d     = conf_q;
    timeout_d  = timeout_q;
    overrun_d  = overrun_q | (capture_done & ((state_q != IDLE) | rv_q));
    trk_clear  = 1'b0;
    trk_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_done && !rv_q) begin
          state_d   = ISSUE;
          idx_d     = '0;
          trk_clear = 1'b1;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sc.scorer_done) begin
          trk_update = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + rank_idx_t'(1);
            state_d = ISSUE;
          end
        end else if (wd_q == WD_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      FINISH: begin
        rank_d   = trk_rank;
        best_d   = trk_best;
        second_d = trk_second;
        conf_d   = (margin >= score_t'(MARGIN_MIN));
        rv_d     = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wd_q      <= '0;
      rv_q      <= 1'b0;
      rank_q    <= '0;
      best_q    <= '0;
      second_q  <= '0;
      conf_q    <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wd_q      <= wd_d;
      rv_q      <= rv_d;
      rank_q    <= rank_d;
      best_q    <= best_d;
      second_q  <= second_d;
      conf_q    <= conf_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign sc.sel_template = idx_q;
  assign sc.scorer_start = (state_q == ISSUE);
  assign busy            = (state_q != IDLE);
  assign result_valid    = rv_q;
  assign best_rank       = rank_q;
  assign best_score      = best_q;
  assign second_score    = second_q;
  assign confident       = conf_q;
  assign overrun         = overrun_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_rank_match_sched.sv
// Bench for rank_match_sched: a behavioural scorer answers each start pulse.
// Expected sweep results are queued when a capture is issued and compared when result_valid fires.
module tb_rank_match_sched;
  import rank_match_pkg::*;

  typedef struct {
    int rank;
    int best;
    int second;
    int conf;
  } exp_t;

  logic      clk = 1'b0;
  logic      rst;
  logic      capture_done;
  logic      busy, result_valid, confident, overrun, timeout_err;
  rank_idx_t best_rank;
  score_t    best_score, second_score;

  rank_match_sched_if sif();

  rank_match_sched dut (
    .clk          (clk),
    .rst          (rst),
    .capture_done (capture_done),
    .sc           (sif),
    .busy         (busy),
    .result_valid (result_valid),
    .best_rank    (best_rank),
    .best_score   (best_score),
    .second_score (second_score),
    .confident    (confident),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  exp_t exp_q[$];
  int   tab[NUM_RANKS];
  int   withhold_idx = -1;
  int   exp_idx = 0;
  int   start_cnt = 0;
  int   rv_cnt = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   wstart_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, expv);
    end
  endtask

  // Reference: the lowest score, the earliest index holding it, and the lowest score among the other indices.
  function automatic exp_t modelSweep();
    exp_t e;
    e.best = 2047;
    e.rank = 0;
    for (int i = 0; i < NUM_RANKS; i++)
      if (tab[i] < e.best) e.best = tab[i];
    for (int i = NUM_RANKS - 1; i >= 0; i--)
      if (tab[i] == e.best) e.rank = i;
    e.second = 2047;
    for (int i = 0; i < NUM_RANKS; i++)
      if (i != e.rank && tab[i] < e.second) e.second = tab[i];
    e.conf = ((e.second - e.best) >= 40) ? 1 : 0;
    return e;
  endfunction

  task automatic setTab(input int val);
    for (int i = 0; i < NUM_RANKS; i++) tab[i] = val;
  endtask

  task automatic applyStimulus(input bit expect_run);
    @(posedge clk); #1;
    capture_done = 1'b1;
    if (expect_run) exp_q.push_back(modelSweep());
    @(posedge clk); #1;
    capture_done = 1'b0;
    if (expect_run) checkOutput("start_latency", 32'(sif.scorer_start), 32'd1);
  endtask

  task automatic waitResult(input int target);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(posedge clk); #2;
      if (rv_cnt >= target) seen = 1'b1;
    end
    if (!seen) checkOutput("result_wait_expired", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
  endtask

  // Behavioural scorer: answers 30 cycles after each start unless that index is withheld or reset hits.
  initial begin
    int cur;
    bit aborted;
    sif.scorer_done  = 1'b0;
    sif.scorer_score = '0;
    forever begin
      @(posedge clk); #1;
      sif.scorer_done = 1'b0;
      if (sif.scorer_start === 1'b1) begin
        cur = int'(sif.sel_template);
        start_cnt++;
        checkOutput("sel_template", 32'(cur), 32'(exp_idx));
        exp_idx++;
        if (cur == withhold_idx) wstart_cyc = cyc;
        aborted = 1'b0;
        for (int k = 0; k < 29; k++) begin
          @(posedge clk); #1;
          if (rst !== 1'b1) aborted = 1'b1;
        end
        if (!aborted && cur != withhold_idx && cur < NUM_RANKS) begin
          sif.scorer_score = score_t'(tab[cur]);
          sif.scorer_done  = 1'b1;
          if (cur == NUM_RANKS - 1) done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("best_rank", 32'(best_rank), 32'(e.rank));
          checkOutput("best_score", 32'(best_score), 32'(e.best));
          checkOutput("second_score", 32'(second_score), 32'(e.second));
          checkOutput("confident", 32'(confident), 32'(e.conf));
          checkOutput("result_latency", 32'(cyc - done_cyc), 32'd2);
          checkOutput("busy_at_result", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    int s0, r0, s_rst;
    bit seen;
    rst = 1'b1;
    capture_done = 1'b0;
    setTab(500);
    #2 rst = 1'b0;
    #5;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_best_score", 32'(best_score), 32'd0);
    checkOutput("rst_start", 32'(sif.scorer_start), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] nominal sweep");
    setTab(500); tab[8] = 120;
    exp_idx = 0; s0 = start_cnt;
    applyStimulus(1'b1);
    waitResult(1);
    checkOutput("nominal_starts", 32'(start_cnt - s0), 32'd13);

    $display("[TB] low margin");
    setTab(600); tab[3] = 200; tab[11] = 220;
    exp_idx = 0;
    applyStimulus(1'b1);
    waitResult(2);

    $display("[TB] tie");
    setTab(900); tab[2] = 150; tab[7] = 150;
    exp_idx = 0;
    applyStimulus(1'b1);
    waitResult(3);

    $display("[TB] overrun");
    setTab(700); tab[5] = 10;
    exp_idx = 0; s0 = start_cnt; r0 = rv_cnt;
    checkOutput("overrun_before", 32'(overrun), 32'd0);
    applyStimulus(1'b1);
    repeat (3) @(posedge clk);
    applyStimulus(1'b0);
    waitResult(r0 + 1);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("overrun_flag", 32'(overrun), 32'd1);
    checkOutput("overrun_starts", 32'(start_cnt - s0), 32'd13);
    checkOutput("overrun_results", 32'(rv_cnt - r0), 32'd1);

    $display("[TB] timeout");
    setTab(300); tab[1] = 50;
    withhold_idx = 4; exp_idx = 0; r0 = rv_cnt;
    applyStimulus(1'b0);
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(posedge clk); #2;
      if (timeout_err === 1'b1) seen = 1'b1;
    end
    checkOutput("timeout_seen", 32'(seen), 32'd1);
    checkOutput("timeout_delay", 32'(cyc - wstart_cyc), 32'd2049);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_no_result", 32'(rv_cnt - r0), 32'd0);
    checkOutput("timeout_keep_rank", 32'(best_rank), 32'd5);
    checkOutput("timeout_keep_best", 32'(best_score), 32'd10);
    checkOutput("timeout_keep_second", 32'(second_score), 32'd700);
    withhold_idx = -1; exp_idx = 0;
    applyStimulus(1'b1);
    waitResult(r0 + 1);
    checkOutput("timeout_sticky", 32'(timeout_err), 32'd1);

    $display("[TB] all-ones scores");
    setTab(2047);
    exp_idx = 0; r0 = rv_cnt;
    applyStimulus(1'b1);
    waitResult(r0 + 1);

    $display("[TB] async reset mid-sweep");
    setTab(400); tab[9] = 30;
    exp_idx = 0; s0 = start_cnt; r0 = rv_cnt;
    applyStimulus(1'b0);
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(posedge clk); #2;
      if (start_cnt >= s0 + 7) seen = 1'b1;
    end
    checkOutput("reset_reached_idx6", 32'(seen), 32'd1);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    s_rst = start_cnt;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_start", 32'(sif.scorer_start), 32'd0);
    checkOutput("arst_sel", 32'(sif.sel_template), 32'd0);
    checkOutput("arst_overrun", 32'(overrun), 32'd0);
    checkOutput("arst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("arst_best_score", 32'(best_score), 32'd0);
    checkOutput("arst_second", 32'(second_score), 32'd0);
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("post_reset_no_start", 32'(start_cnt - s_rst), 32'd0);
    checkOutput("post_reset_no_result", 32'(rv_cnt - r0), 32'd0);
    exp_idx = 0;
    applyStimulus(1'b1);
    waitResult(r0 + 1);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
